// File: rtl/ysyx_25020037_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_25020037_wbu -- write-back stage
//
// Takes one retired instruction per handshake from the LSU and commits its
// architectural effects: GPR write, CSR write, and trap entry/return (ecall,
// mret, load/store access fault). Also hosts the GPR file and the machine
// CSRs, and exposes combinational read ports for decode.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   lsu_valid          LSU presents a retired instruction
//   wbu_ready          WBU can accept this cycle (high only in IDLE)
//   in_*               instruction payload, latched on the accept edge
//   rs1_addr/rs2_addr  decode GPR read addresses
//   rs1_data/rs2_data  committed GPR contents (x0 reads as 0)
//   csr_raddr          decode CSR read address
//   csr_rdata          committed CSR contents (unknown CSRs read as 0)
//   commit_valid/pc    one-cycle pulse + PC of the instruction committing
//   redirect_valid/pc  one-cycle pulse + target when fetch must jump
//
// Timing: accept edge -> one COMMIT cycle -> commit edge. Commit/redirect
// outputs are registered on the accept edge so they are high exactly during
// the COMMIT cycle; architectural state changes on the commit edge, so reads
// in the COMMIT cycle still see the old values.
// ----------------------------------------------------------------------------
module ysyx_25020037_wbu #(
    parameter logic [31:0] ARCH_ID     = 32'd25020037,
    parameter logic [31:0] VENDOR_ID   = 32'h79737978,
    parameter logic [31:0] MSTATUS_RST = 32'h00001800
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        lsu_valid,
    output logic        wbu_ready,
    input  logic [31:0] in_pc,
    input  logic        in_rd_wen,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_rd_wdata,
    input  logic        in_csr_wen,
    input  logic [11:0] in_csr_addr,
    input  logic [31:0] in_csr_wdata,
    input  logic        in_ecall,
    input  logic        in_mret,
    input  logic        in_fault,
    input  logic        in_fault_store,
    input  logic [31:0] in_fault_addr,

    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,

    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_COMMIT = 1'b1;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
    localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
    localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;

    logic [0:0]  state;

    // Instruction payload captured on the accept edge
    logic [31:0] l_pc;
    logic        l_rd_wen;
    logic [4:0]  l_rd;
    logic [31:0] l_rd_wdata;
    logic        l_csr_wen;
    logic [11:0] l_csr_addr;
    logic [31:0] l_csr_wdata;
    logic        l_ecall;
    logic        l_mret;
    logic        l_fault;
    logic        l_fault_store;
    logic [31:0] l_fault_addr;

    // Architectural state
    logic [31:0] gpr [32];
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;

    logic        commit_valid_q;
    logic        redirect_valid_q;

    logic        accept;
    logic        in_trap;
    logic        in_redirect;
    logic        in_commit;
    logic        c_trap;
    logic        c_normal;
    logic        gpr_we;
    logic        csr_we;
    logic [31:0] trap_vector;

    assign wbu_ready   = (state == S_IDLE);
    assign accept      = lsu_valid & wbu_ready;
    assign in_trap     = in_fault | in_ecall;
    assign in_redirect = in_trap | in_mret;
    assign trap_vector = {mtvec[31:2], 2'b00};

    // Commit-cycle decode. Fault and ecall share one trap path (cause/tval
    // differ); mret only acts when no trap is present; everything else is a
    // plain write-back.
    assign in_commit = (state == S_COMMIT);
    assign c_trap    = in_commit & (l_fault | l_ecall);
    assign c_normal  = in_commit & ~l_fault & ~l_ecall & ~l_mret;
    assign gpr_we    = c_normal & l_rd_wen & (l_rd != 5'd0);
    assign csr_we    = c_normal & l_csr_wen;

    // The pulses are held low while reset is asserted so an instruction that
    // is discarded mid-COMMIT never appears as committed or redirecting.
    assign commit_valid   = commit_valid_q & ~rst;
    assign redirect_valid = redirect_valid_q & ~rst;

    // ------------------------------------------------------------------------
    // Control, payload latch, CSRs
    // ------------------------------------------------------------------------
    // NOTE: every sequential assignment uses <= so all registers sample the
    // pre-edge values; a blocking = here would let later statements see
    // half-updated state (e.g. MPIE picking up the new MIE).
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            commit_valid_q   <= 1'b0;
            commit_pc        <= 32'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc      <= 32'd0;
            mstatus          <= MSTATUS_RST;
            mtvec            <= 32'd0;
            mepc             <= 32'd0;
            mcause           <= 32'd0;
            mtval            <= 32'd0;
            l_pc             <= 32'd0;
            l_rd_wen         <= 1'b0;
            l_rd             <= 5'd0;
            l_rd_wdata       <= 32'd0;
            l_csr_wen        <= 1'b0;
            l_csr_addr       <= 12'd0;
            l_csr_wdata      <= 32'd0;
            l_ecall          <= 1'b0;
            l_mret           <= 1'b0;
            l_fault          <= 1'b0;
            l_fault_store    <= 1'b0;
            l_fault_addr     <= 32'd0;
        end else begin
            commit_valid_q   <= 1'b0;
            redirect_valid_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state         <= S_COMMIT;
                        l_pc          <= in_pc;
                        l_rd_wen      <= in_rd_wen;
                        l_rd          <= in_rd;
                        l_rd_wdata    <= in_rd_wdata;
                        l_csr_wen     <= in_csr_wen;
                        l_csr_addr    <= in_csr_addr;
                        l_csr_wdata   <= in_csr_wdata;
                        l_ecall       <= in_ecall;
                        l_mret        <= in_mret;
                        l_fault       <= in_fault;
                        l_fault_store <= in_fault_store;
                        l_fault_addr  <= in_fault_addr;

                        // mtvec/mepc cannot change between accept and commit,
                        // so the redirect target is resolved now and the
                        // pulse lines up with the COMMIT cycle.
                        commit_valid_q <= 1'b1;
                        commit_pc      <= in_pc;
                        if (in_redirect) begin
                            redirect_valid_q <= 1'b1;
                            redirect_pc      <= in_trap ? trap_vector : mepc;
                        end
                    end
                end

                S_COMMIT: begin
                    state <= S_IDLE;

                    if (c_trap) begin
                        mepc   <= l_pc;
                        mcause <= l_fault ? (l_fault_store ? CAUSE_STORE_FAULT
                                                           : CAUSE_LOAD_FAULT)
                                          : CAUSE_ECALL_M;
                        mtval  <= l_fault ? l_fault_addr : 32'd0;
                        // MPP<=M, MPIE<=MIE, MIE<=0
                        mstatus <= {mstatus[31:13], 2'b11, mstatus[10:8],
                                    mstatus[3], mstatus[6:4], 1'b0,
                                    mstatus[2:0]};
                    end else if (l_mret) begin
                        // MIE<=MPIE, MPIE<=1
                        mstatus <= {mstatus[31:8], 1'b1, mstatus[6:4],
                                    mstatus[7], mstatus[2:0]};
                    end else if (csr_we) begin
                        case (l_csr_addr)
                            CSR_MSTATUS: mstatus <= l_csr_wdata;
                            CSR_MTVEC:   mtvec   <= l_csr_wdata;
                            CSR_MEPC:    mepc    <= l_csr_wdata;
                            CSR_MCAUSE:  mcause  <= l_csr_wdata;
                            CSR_MTVAL:   mtval   <= l_csr_wdata;
                            default: ;   // read-only or unimplemented
                        endcase
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // GPR file
    // ------------------------------------------------------------------------
    // NOTE: the register file is explicitly cleared on reset because software
    // observes all-zero GPRs after reset; x0 is never written so it stays 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= 32'd0;
            end
        end else if (gpr_we) begin
            gpr[l_rd] <= l_rd_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: committed state only, no bypass of the in-flight write
    // ------------------------------------------------------------------------
    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : gpr[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : gpr[rs2_addr];

    // NOTE: csr_rdata gets a default before the case so no address pattern
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_raddr)
            CSR_MSTATUS:   csr_rdata = mstatus;
            CSR_MTVEC:     csr_rdata = mtvec;
            CSR_MEPC:      csr_rdata = mepc;
            CSR_MCAUSE:    csr_rdata = mcause;
            CSR_MTVAL:     csr_rdata = mtval;
            CSR_MVENDORID: csr_rdata = VENDOR_ID;
            CSR_MARCHID:   csr_rdata = ARCH_ID;
            default:       csr_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25020037_wbu -- self-checking bench for the write-back stage.
// Directed scenarios followed by random instructions, all compared against a
// behavioural model of the architectural state (GPR array + CSR variables).
// ----------------------------------------------------------------------------
module tb_ysyx_25020037_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        wbu_ready;
    logic [31:0] in_pc;
    logic        in_rd_wen;
    logic [4:0]  in_rd;
    logic [31:0] in_rd_wdata;
    logic        in_csr_wen;
    logic [11:0] in_csr_addr;
    logic [31:0] in_csr_wdata;
    logic        in_ecall;
    logic        in_mret;
    logic        in_fault;
    logic        in_fault_store;
    logic [31:0] in_fault_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ysyx_25020037_wbu dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid      (lsu_valid),
        .wbu_ready      (wbu_ready),
        .in_pc          (in_pc),
        .in_rd_wen      (in_rd_wen),
        .in_rd          (in_rd),
        .in_rd_wdata    (in_rd_wdata),
        .in_csr_wen     (in_csr_wen),
        .in_csr_addr    (in_csr_addr),
        .in_csr_wdata   (in_csr_wdata),
        .in_ecall       (in_ecall),
        .in_mret        (in_mret),
        .in_fault       (in_fault),
        .in_fault_store (in_fault_store),
        .in_fault_addr  (in_fault_addr),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        rd_wen;
        logic [4:0]  rd;
        logic [31:0] rd_wdata;
        logic        csr_wen;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic        ecall;
        logic        mret;
        logic        fault;
        logic        fault_store;
        logic [31:0] fault_addr;
    } instr_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: architectural state after each committed instruction
    // ------------------------------------------------------------------------
    logic [31:0] m_gpr [32];
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic [31:0] m_commit_pc, m_redirect_pc;

    localparam logic [11:0] CSR_LIST [7] = '{12'h300, 12'h305, 12'h341,
                                             12'h342, 12'h343, 12'hF11, 12'hF12};

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_mstatus     = 32'h00001800;
        m_mtvec       = 32'd0;
        m_mepc        = 32'd0;
        m_mcause      = 32'd0;
        m_mtval       = 32'd0;
        m_commit_pc   = 32'd0;
        m_redirect_pc = 32'd0;
    endfunction

    function automatic logic [31:0] model_csr(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hF11: return 32'h79737978;
            12'hF12: return 32'd25020037;
            default: return 32'd0;
        endcase
    endfunction

    // Applies one instruction; returns whether fetch is redirected.
    function automatic logic model_commit(input instr_t i);
        logic mie;
        logic redir;
        redir = 1'b0;
        m_commit_pc = i.pc;
        if (i.fault || i.ecall) begin
            redir         = 1'b1;
            m_redirect_pc = m_mtvec & 32'hFFFF_FFFC;
            m_mepc        = i.pc;
            if (i.fault) begin
                m_mcause = i.fault_store ? 32'd7 : 32'd5;
                m_mtval  = i.fault_addr;
            end else begin
                m_mcause = 32'd11;
                m_mtval  = 32'd0;
            end
            mie               = m_mstatus[3];
            m_mstatus[7]      = mie;
            m_mstatus[3]      = 1'b0;
            m_mstatus[12:11]  = 2'b11;
        end else if (i.mret) begin
            redir         = 1'b1;
            m_redirect_pc = m_mepc;
            m_mstatus[3]  = m_mstatus[7];
            m_mstatus[7]  = 1'b1;
        end else begin
            if (i.rd_wen && i.rd != 5'd0) m_gpr[i.rd] = i.rd_wdata;
            if (i.csr_wen) begin
                case (i.csr_addr)
                    12'h300: m_mstatus = i.csr_wdata;
                    12'h305: m_mtvec   = i.csr_wdata;
                    12'h341: m_mepc    = i.csr_wdata;
                    12'h342: m_mcause  = i.csr_wdata;
                    12'h343: m_mtval   = i.csr_wdata;
                    default: ;
                endcase
            end
        end
        return redir;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    function automatic instr_t blank(input logic [31:0] pc);
        instr_t i;
        i.pc = pc;          i.rd_wen = 1'b0;     i.rd = 5'd0;
        i.rd_wdata = 32'd0; i.csr_wen = 1'b0;    i.csr_addr = 12'd0;
        i.csr_wdata = 32'd0; i.ecall = 1'b0;     i.mret = 1'b0;
        i.fault = 1'b0;     i.fault_store = 1'b0; i.fault_addr = 32'd0;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        in_pc          = i.pc;
        in_rd_wen      = i.rd_wen;
        in_rd          = i.rd;
        in_rd_wdata    = i.rd_wdata;
        in_csr_wen     = i.csr_wen;
        in_csr_addr    = i.csr_addr;
        in_csr_wdata   = i.csr_wdata;
        in_ecall       = i.ecall;
        in_mret        = i.mret;
        in_fault       = i.fault;
        in_fault_store = i.fault_store;
        in_fault_addr  = i.fault_addr;
    endtask

    // Called just after a clock edge; reads land on odd offsets, clear of edges.
    task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
        csr_raddr = a;
        #2;
        d = csr_rdata;
    endtask

    task automatic check_state(input logic [4:0] r);
        logic [31:0] d;
        rs1_addr = r;
        rs2_addr = 5'($urandom_range(0, 31));
        #2;
        check("gpr_rs1", rs1_data, m_gpr[r]);
        check("gpr_rs2", rs2_data, m_gpr[rs2_addr]);
        foreach (CSR_LIST[k]) begin
            read_csr(CSR_LIST[k], d);
            check($sformatf("csr_%03h", CSR_LIST[k]), d, model_csr(CSR_LIST[k]));
        end
    endtask

    // Full handshake for one instruction with checks in COMMIT and after.
    task automatic issue(input instr_t i);
        int          waited;
        logic [31:0] old_rd;
        logic [31:0] old_cause;
        logic        redir;
        waited = 0;
        while (!wbu_ready && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!wbu_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        drive(i);
        lsu_valid = 1'b1;
        rs1_addr  = i.rd;
        csr_raddr = 12'h342;
        old_rd    = m_gpr[i.rd];
        old_cause = m_mcause;
        redir     = model_commit(i);

        @(posedge clk); #1;
        lsu_valid = 1'b0;
        check("commit_ready_low", wbu_ready, 32'd0);
        check("commit_valid", commit_valid, 32'd1);
        check("commit_pc", commit_pc, m_commit_pc);
        check("redirect_valid", redirect_valid, redir);
        check("redirect_pc", redirect_pc, m_redirect_pc);
        check("no_bypass_gpr", rs1_data, old_rd);
        check("no_bypass_csr", csr_rdata, old_cause);

        @(posedge clk); #1;
        check("idle_ready", wbu_ready, 32'd1);
        check("idle_commit_valid", commit_valid, 32'd0);
        check("idle_redirect_valid", redirect_valid, 32'd0);
        check("hold_commit_pc", commit_pc, m_commit_pc);
        check("hold_redirect_pc", redirect_pc, m_redirect_pc);
        check_state(i.rd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        instr_t      i;
        instr_t      q [6];
        logic [31:0] d;
        logic        prior_mpie;
        logic        unused_redir;

        rst = 1'b1; lsu_valid = 1'b0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; csr_raddr = 12'd0;
        drive(blank(32'd0));
        do_reset();

        // Reset state
        check("rst_ready", wbu_ready, 32'd1);
        check("rst_commit_valid", commit_valid, 32'd0);
        check("rst_redirect_valid", redirect_valid, 32'd0);
        check("rst_commit_pc", commit_pc, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        read_csr(12'h300, d);
        check("rst_mstatus", d, 32'h00001800);
        check_state(5'd1);

        // GPR write and x0 protection
        i = blank(32'h8000_0000); i.rd_wen = 1'b1; i.rd = 5'd5;
        i.rd_wdata = 32'hDEAD_BEEF;
        issue(i);
        rs1_addr = 5'd5; #2;
        check("x5_deadbeef", rs1_data, 32'hDEAD_BEEF);
        i = blank(32'h8000_0004); i.rd_wen = 1'b1; i.rd = 5'd0;
        i.rd_wdata = 32'h1234_5678;
        issue(i);
        rs1_addr = 5'd0; #2;
        check("x0_zero", rs1_data, 32'd0);

        // mtvec write, ecall, mret
        i = blank(32'h8000_0008); i.csr_wen = 1'b1; i.csr_addr = 12'h305;
        i.csr_wdata = 32'h8000_0103;
        issue(i);
        read_csr(12'h300, d);
        prior_mpie = d[3];     // MIE becomes MPIE on trap entry
        i = blank(32'h8000_0010); i.ecall = 1'b1;
        issue(i);
        check("ecall_redirect_pc", redirect_pc, 32'h8000_0100);
        read_csr(12'h341, d); check("ecall_mepc", d, 32'h8000_0010);
        read_csr(12'h342, d); check("ecall_mcause", d, 32'd11);
        read_csr(12'h300, d); check("ecall_mie", d[3], 32'd0);
        check("ecall_mpie", d[7], prior_mpie);
        check("ecall_mpp", d[12:11], 32'd3);

        i = blank(32'h8000_0100); i.mret = 1'b1;
        issue(i);
        check("mret_redirect_pc", redirect_pc, 32'h8000_0010);
        read_csr(12'h300, d);
        check("mret_mie", d[3], prior_mpie);
        check("mret_mpie", d[7], 32'd1);

        // Load fault, store fault
        i = blank(32'h8000_0020); i.fault = 1'b1; i.fault_addr = 32'hA000_0004;
        i.rd_wen = 1'b1; i.rd = 5'd3; i.rd_wdata = 32'h5555_AAAA;
        issue(i);
        read_csr(12'h342, d); check("load_fault_mcause", d, 32'd5);
        read_csr(12'h343, d); check("load_fault_mtval", d, 32'hA000_0004);
        rs1_addr = 5'd3; #2;
        check("load_fault_x3", rs1_data, 32'd0);
        i = blank(32'h8000_0024); i.fault = 1'b1; i.fault_store = 1'b1;
        i.fault_addr = 32'hA000_0008;
        issue(i);
        read_csr(12'h342, d); check("store_fault_mcause", d, 32'd7);

        // Fault wins over ecall and CSR write
        i = blank(32'h8000_0028); i.fault = 1'b1; i.ecall = 1'b1;
        i.csr_wen = 1'b1; i.csr_addr = 12'h305; i.csr_wdata = 32'hFFFF_FFFF;
        issue(i);
        read_csr(12'h342, d); check("prio_mcause", d, 32'd5);
        read_csr(12'h305, d); check("prio_mtvec", d, 32'h8000_0103);

        // marchid / mvendorid
        read_csr(12'hF12, d); check("marchid", d, 32'd25020037);
        read_csr(12'hF11, d); check("mvendorid", d, 32'h79737978);

        // Back-to-back with lsu_valid held high
        foreach (q[k]) begin
            q[k] = blank(32'h9000_0000 + 32'(k) * 4);
            q[k].rd_wen = 1'b1; q[k].rd = 5'(10 + k);
            q[k].rd_wdata = $urandom;
        end
        drive(q[0]);
        lsu_valid = 1'b1;
        foreach (q[k]) begin
            @(posedge clk); #1;
            check("b2b_commit_valid", commit_valid, 32'd1);
            check("b2b_commit_pc", commit_pc, q[k].pc);
            check("b2b_ready_low", wbu_ready, 32'd0);
            unused_redir = model_commit(q[k]);
            if (k + 1 < 6) drive(q[k + 1]);
            else           lsu_valid = 1'b0;
            @(posedge clk); #1;
            check("b2b_idle_valid", commit_valid, 32'd0);
            check("b2b_idle_ready", wbu_ready, 32'd1);
        end
        for (int r = 0; r < 32; r++) begin
            rs1_addr = 5'(r);
            #2;
            check($sformatf("b2b_x%0d", r), rs1_data, m_gpr[r]);
        end
        @(posedge clk); #1;

        // Reset asserted while in COMMIT discards the instruction
        i = blank(32'h8000_0040); i.rd_wen = 1'b1; i.rd = 5'd7;
        i.rd_wdata = 32'hCAFE_F00D; i.csr_wen = 1'b1; i.csr_addr = 12'h341;
        i.csr_wdata = 32'h1111_2222;
        drive(i);
        lsu_valid = 1'b1;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_in_commit_valid", commit_valid, 32'd0);
        check("rst_in_commit_redirect", redirect_valid, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("rst_in_commit_pc", commit_pc, 32'd0);
        check("rst_in_commit_ready", wbu_ready, 32'd1);
        check_state(5'd7);
        check_state(5'd5);

        // Random instructions
        for (int n = 0; n < 200; n++) begin
            i = blank({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            i.rd_wen      = 1'($urandom);
            i.rd          = 5'($urandom);
            i.rd_wdata    = $urandom;
            i.csr_wen     = ($urandom_range(0, 2) == 0);
            i.csr_addr    = ($urandom_range(0, 7) == 7) ? 12'h7C0
                                                        : CSR_LIST[$urandom_range(0, 6)];
            i.csr_wdata   = $urandom;
            i.ecall       = ($urandom_range(0, 7) == 0);
            i.mret        = ($urandom_range(0, 7) == 0);
            i.fault       = ($urandom_range(0, 7) == 0);
            i.fault_store = 1'($urandom);
            i.fault_addr  = $urandom;
            issue(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
